fifo_pipe_delay: RTL and testbench

FIFO_PIPE_DELAY -- requirements
Module: fifo_pipe_delay

---
 rtl/fifo_pipe_delay_if.sv | 54 +++++
 rtl/fifo_pipe_delay.sv | 153 +++++++++++++++
 tb/tb_fifo_pipe_delay.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pipe_delay_if.sv
// Handshake and status bundle between a FIFO user (master) and fifo_pipe_delay (slave).
// Widths follow the same DATA_WIDTH / FIFO_DEPTH parameters as the FIFO itself.
interface fifo_pipe_delay_if #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush,
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  flush,
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output rd_valid,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/fifo_pipe_delay.sv
// Synchronous FIFO whose read words travel through a fixed, non-stalling delay pipeline
// before appearing on rd_data/rd_valid; all status flags are registered.
module fifo_pipe_delay #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int PIPE_DEPTH = 4,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic              clk,
    input logic              rst_n,
    fifo_pipe_delay_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;

    logic full_q,      full_d;
    logic empty_q,     empty_d;
    logic af_q,        af_d;
    logic ae_q,        ae_d;
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    logic [DATA_WIDTH-1:0] pipe_data_q [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] pipe_data_d [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] pipe_valid_q, pipe_valid_d;

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic          wr_accept;
    logic          rd_accept;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    // Accept decisions use the flags registered before this edge.
    always_comb begin
        wr_accept = bus.wr_en && !full_q;
        rd_accept = bus.rd_en && !empty_q;
        wr_addr   = wr_ptr_q[AW-1:0];
        rd_addr   = rd_ptr_q[AW-1:0];
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q  | (bus.wr_en & full_q);
        underflow_d = underflow_q | (bus.rd_en & empty_q);

        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end
        end

        // Wrap-bit pointer difference is the occupancy, 0..FIFO_DEPTH.
        count_d = wr_ptr_d - rd_ptr_d;
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_comb begin
        pipe_data_d[0]  = mem_q[rd_addr];
        pipe_valid_d    = '0;
        pipe_valid_d[0] = rd_accept && !bus.flush;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipe_data_d[i]  = pipe_data_q[i-1];
            pipe_valid_d[i] = pipe_valid_q[i-1] && !bus.flush;
        end

        // Output register after the last stage gives the full PIPE_DEPTH latency.
        rd_data_d  = pipe_data_q[PIPE_DEPTH-1];
        rd_valid_d = pipe_valid_q[PIPE_DEPTH-1] && !bus.flush;
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !bus.flush) begin
            mem_q[wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            af_q         <= 1'b0;
            ae_q         <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            pipe_valid_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_data_q[i] <= '0;
            end
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            af_q         <= af_d;
            ae_q         <= ae_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            pipe_valid_q <= pipe_valid_d;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH_C);
    a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst_n) !(full_q && empty_q));

endmodule

// File: tb/tb_fifo_pipe_delay.sv
// Directed bench for fifo_pipe_delay (4-bit data, 16 entries, 4-stage read delay).
// Expected values are hand-derived from cycle indices in each stimulus loop.
module tb_fifo_pipe_delay;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checkCount = 0;
    int   failCount = 0;

    fifo_pipe_delay_if #(.DATA_WIDTH(4), .FIFO_DEPTH(16)) bus_if ();

    fifo_pipe_delay #(
        .DATA_WIDTH(4),
        .FIFO_DEPTH(16),
        .PIPE_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic w, input logic [3:0] d, input logic r, input logic f);
        bus_if.wr_en   = w;
        bus_if.wr_data = d;
        bus_if.rd_en   = r;
        bus_if.flush   = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus_if.flush   = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = 4'h0;
        bus_if.rd_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", bus_if.count, 0);
        checkOutput("rst_empty", bus_if.empty, 1);
        checkOutput("rst_ae", bus_if.almost_empty, 1);
        checkOutput("rst_full", bus_if.full, 0);
        checkOutput("rst_af", bus_if.almost_full, 0);
        checkOutput("rst_rd_valid", bus_if.rd_valid, 0);
        checkOutput("rst_rd_data", bus_if.rd_data, 0);
        checkOutput("rst_overflow", bus_if.overflow, 0);
        checkOutput("rst_underflow", bus_if.underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word latency: write edge 1, read edge 2, data after edge 6.
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        checkOutput("lat_count1", bus_if.count, 1);
        checkOutput("lat_empty1", bus_if.empty, 0);
        checkOutput("lat_ae1", bus_if.almost_empty, 1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("lat_count0", bus_if.count, 0);
        checkOutput("lat_empty0", bus_if.empty, 1);
        checkOutput("lat_valid_e2", bus_if.rd_valid, 0);
        for (int k = 3; k <= 7; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
            checkOutput($sformatf("lat_valid_e%0d", k), bus_if.rd_valid, (k == 6));
            if (k == 6) checkOutput("lat_data_e6", bus_if.rd_data, 4'h3);
        end

        // Fill to full, overflow on 17th write, drain in order.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
            if (i == 1)  checkOutput("fill_ae_c2", bus_if.almost_empty, 1);
            if (i == 2)  checkOutput("fill_ae_c3", bus_if.almost_empty, 0);
            if (i == 12) checkOutput("fill_af_c13", bus_if.almost_full, 0);
            if (i == 13) checkOutput("fill_af_c14", bus_if.almost_full, 1);
            if (i == 14) checkOutput("fill_full_c15", bus_if.full, 0);
        end
        checkOutput("fill_full", bus_if.full, 1);
        checkOutput("fill_count", bus_if.count, 16);
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
        checkOutput("ovf_count", bus_if.count, 16);
        checkOutput("ovf_full", bus_if.full, 1);
        checkOutput("ovf_flag", bus_if.overflow, 1);
        for (int j = 0; j < 20; j++) begin
            applyStimulus(1'b0, 4'h0, (j < 16), 1'b0);
            checkOutput($sformatf("drain_valid%0d", j), bus_if.rd_valid, (j >= 4));
            if (j >= 4) checkOutput($sformatf("drain_data%0d", j), bus_if.rd_data, j - 4);
        end
        checkOutput("drain_empty", bus_if.empty, 1);
        checkOutput("drain_count", bus_if.count, 0);
        checkOutput("drain_ovf_sticky", bus_if.overflow, 1);
        checkOutput("drain_underflow", bus_if.underflow, 0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkOutput("flush_ovf_clr", bus_if.overflow, 0);

        // At full, simultaneous write and read: read wins, write dropped.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        checkOutput("rw_full_pre", bus_if.full, 1);
        applyStimulus(1'b1, 4'h9, 1'b1, 1'b0);
        checkOutput("rw_full_count", bus_if.count, 15);
        checkOutput("rw_full_flag", bus_if.full, 0);
        checkOutput("rw_full_ovf", bus_if.overflow, 1);
        for (int j = 1; j < 20; j++) begin
            applyStimulus(1'b0, 4'h0, (j <= 15), 1'b0);
            checkOutput($sformatf("rw_valid%0d", j), bus_if.rd_valid, (j >= 4));
            if (j >= 4) checkOutput($sformatf("rw_data%0d", j), bus_if.rd_data, j - 4);
        end
        checkOutput("rw_empty", bus_if.empty, 1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

        // At empty, simultaneous write and read: write lands, no fall-through.
        applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
        checkOutput("emp_underflow", bus_if.underflow, 1);
        checkOutput("emp_count", bus_if.count, 1);
        checkOutput("emp_empty", bus_if.empty, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
            checkOutput($sformatf("emp_nofall%0d", k), bus_if.rd_valid, 0);
        end
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("emp_read_count", bus_if.count, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
            checkOutput($sformatf("emp_rd_valid%0d", k), bus_if.rd_valid, (k == 4));
            if (k == 4) checkOutput("emp_rd_data", bus_if.rd_data, 4'hA);
        end

        // Pointer wrap: 12 in, 12 out, then 10 interleaved write/read pairs.
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        checkOutput("wrap_count12", bus_if.count, 12);
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b0, 4'h0, (j < 12), 1'b0);
            checkOutput($sformatf("wrap_a_valid%0d", j), bus_if.rd_valid, (j >= 4));
            if (j >= 4) checkOutput($sformatf("wrap_a_data%0d", j), bus_if.rd_data, j - 4);
        end
        for (int j = 0; j < 24; j++) begin
            applyStimulus((j % 2 == 0) && (j < 20), 4'(j / 2 + 6), (j % 2 == 1) && (j < 20), 1'b0);
            checkOutput($sformatf("wrap_b_count%0d", j), bus_if.count, ((j < 20) && (j % 2 == 0)) ? 1 : 0);
            checkOutput($sformatf("wrap_b_valid%0d", j), bus_if.rd_valid, (j >= 5) && ((j - 5) % 2 == 0));
            if ((j >= 5) && ((j - 5) % 2 == 0))
                checkOutput($sformatf("wrap_b_data%0d", j), bus_if.rd_data, (j - 5) / 2 + 6);
        end

        // Flush with three reads in flight.
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("fl_underflow_set", bus_if.underflow, 1);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'hE, 1'b1, 1'b1);
        checkOutput("fl_count", bus_if.count, 0);
        checkOutput("fl_empty", bus_if.empty, 1);
        checkOutput("fl_underflow", bus_if.underflow, 0);
        checkOutput("fl_overflow", bus_if.overflow, 0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
            checkOutput($sformatf("fl_valid%0d", k), bus_if.rd_valid, 0);
        end
        checkOutput("fl_count_after", bus_if.count, 0);

        // Asynchronous reset mid-cycle while a word is on the output.
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("ar_pre_valid", bus_if.rd_valid, 1);
        checkOutput("ar_pre_data", bus_if.rd_data, 1);
        checkOutput("ar_pre_count", bus_if.count, 1);
        bus_if.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", bus_if.rd_valid, 0);
        checkOutput("ar_data", bus_if.rd_data, 0);
        checkOutput("ar_count", bus_if.count, 0);
        checkOutput("ar_empty", bus_if.empty, 1);
        checkOutput("ar_ae", bus_if.almost_empty, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
            checkOutput($sformatf("ar_post_valid%0d", k), bus_if.rd_valid, 0);
        end
        checkOutput("ar_post_count", bus_if.count, 0);
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
            checkOutput($sformatf("ar_new_valid%0d", k), bus_if.rd_valid, (k == 4));
            if (k == 4) checkOutput("ar_new_data", bus_if.rd_data, 4'h7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
